sdram_arbmod: RTL
=================

SDRAM_ARBMOD -- requirements
Module: sdram_arbmod

Interface
REQ-001 SHALL have port CLOCK, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports iCallA / iCallB, input, 2 bits each: client requests, [1] Write and [0] Read.
REQ-004 SHALL have ports oDoneA / oDoneB, output, 2 bits each: one-cycle completion pulses, bit-aligned with iCall.
REQ-005 SHALL have ports iDataA / iDataB, input, 16 bits each: client write data.
REQ-006 SHALL have ports oDataA / oDataB, output, 16 bits each: read data, broadcast from iData.
REQ-007 SHALL have ports oTagA / oTagB, output, 2 bits each: iTag when that client is granted, else 2'b00.
REQ-008 SHALL have port oCall, output, 2 bits: request to the SDRAM base module, [1] Write and [0] Read.
REQ-009 SHALL have port iDone, input, 2 bits: completion from the SDRAM base module.
REQ-010 SHALL have port iTag, input, 2 bits: tag from the SDRAM base module.
REQ-011 SHALL have port oData, output, 16 bits: muxed write data to the base module.
REQ-012 SHALL have port iData, input, 16 bits: read data from the base module.
REQ-013 SHALL have port oGrant, output, 2 bits: one-hot current owner, [1] B and [0] A; 2'b00 when idle.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE; at most one transaction outstanding.
REQ-015 IDLE SHALL sample both clients: no request stays in IDLE; one requester is granted; if both request, the arbitration rule (REQ-022) decides.
REQ-016 Within the granted client, iCall[1] SHALL win over iCall[0]; the chosen bit SHALL be latched as op (Write or Read) for the whole transaction.
REQ-017 In ISSUE, oCall SHALL hold the one-hot latched op, asserted from the cycle after the grant until the cycle iDone[op] is seen high.
REQ-018 On iDone[op]=1 in ISSUE: the owner's oDone[op] SHALL pulse for exactly 1 cycle (registered, next edge), oCall SHALL drop to 2'b00 on the same edge, and the FSM SHALL go to DRAIN.
REQ-019 DRAIN SHALL last exactly 1 cycle with oCall=0, so the base module sees call low before any new grant; then IDLE.
REQ-020 iDone bits other than op, and any iDone outside ISSUE, SHALL be ignored.
REQ-021 oData SHALL equal the owner's iData while in ISSUE, and 16'h0000 otherwise.
REQ-022 Arbitration is round-robin when SDRAM_ARB_RR_EN is defined: on a tie, the client not served last wins; the last-served register resets to B, so A wins the first tie.
REQ-023 A client that drops iCall mid-ISSUE SHALL NOT abort the transaction: the arbiter completes it and still pulses oDone.
REQ-024 Grant-to-oCall latency SHALL be 1 cycle; iDone-to-oDone latency SHALL be 1 cycle; minimum back-to-back spacing SHALL be 4 cycles.

Reset
REQ-025 RESET=1 SHALL force state IDLE, oCall=0, oDoneA=oDoneB=0, oGrant=0, oData=0 and last-served=B, regardless of state (an in-flight ISSUE is abandoned without an oDone pulse).

Configuration
REQ-026 Macro SDRAM_ARB_RR_EN: when defined, round-robin per REQ-022; when undefined, fixed priority with A always winning ties and the last-served register removed.

Structure
REQ-027 Package sdram_arb_pkg SHALL hold the FSM state encoding (IDLE, ISSUE, DRAIN), call bit indices (CALL_WR=1, CALL_RD=0) and the data width constant 16.
REQ-028 Tie-break and grant selection SHALL live in sub-module sdram_arbselmod (inputs: requests and last-served; output: one-hot grant); FSM and muxing SHALL stay in sdram_arbmod.

Verification
REQ-029 iCallA=2'b01 alone, iDone[0] 5 cycles later -> oGrant=01, oCall=01 for 5 cycles, oDoneA=01 for 1 cycle, oCall=00 during DRAIN.
REQ-030 iCallA=2'b10 and iCallB=2'b10 held with RR -> grants A, B, A, B; oData alternates between iDataA=16'hAAAA and iDataB=16'h5555.
REQ-031 Same stimulus as REQ-030 with SDRAM_ARB_RR_EN undefined -> A is served each time it re-requests in IDLE; B waits.
REQ-032 iCallB=2'b11 -> a Write is issued first (oCall=10), then, on re-arbitration, a Read (oCall=01).
REQ-033 RESET pulsed mid-ISSUE -> the next cycle shows oCall=0 and oGrant=0 with no oDone pulse; a spurious iDone[1] then produces no oDone.
REQ-034 iCallA dropped during ISSUE -> the transaction still completes and oDoneA pulses once; iTag=2'b11 appears on oTagA only, and oTagB=00.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// sdram_arb_pkg : shared types and constants for the two-client SDRAM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CALL_WR = 1;
  localparam int CALL_RD = 0;
  localparam int DATA_W  = 16;

  // Last-served encoding: 1 means client B was served most recently.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  function automatic logic [1:0] opToCall(input logic isWrite);
    logic [1:0] call;
    call = 2'b00;
    if (isWrite) call[CALL_WR] = 1'b1;
    else         call[CALL_RD] = 1'b1;
    return call;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arbselmod.sv
// ============================================================================
// sdram_arbselmod : one-hot grant selection between clients A and B
// Rev 1.0
// ============================================================================
`default_nettype none

module sdram_arbselmod
  import sdram_arb_pkg::*;
(
  input  logic       reqA,
  input  logic       reqB,
  input  logic       lastServed,
  output logic [1:0] grant
);

  // On a tie the client that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (reqA && reqB)
      grant = (lastServed == LAST_B) ? 2'b01 : 2'b10;
    else if (reqA)
      grant = 2'b01;
    else if (reqB)
      grant = 2'b10;
  end

endmodule

`default_nettype wire

// File: rtl/sdram_arbmod.sv
// ============================================================================
// sdram_arbmod : two-client arbiter in front of an SDRAM base module.
// Round-robin tie-break when SDRAM_ARB_RR_EN is defined, else A always wins.
// Rev 1.0
// ============================================================================
`default_nettype none

module sdram_arbmod
  import sdram_arb_pkg::*;
(
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [1:0]        iCallA,
  input  logic [1:0]        iCallB,
  output logic [1:0]        oDoneA,
  output logic [1:0]        oDoneB,
  input  logic [DATA_W-1:0] iDataA,
  input  logic [DATA_W-1:0] iDataB,
  output logic [DATA_W-1:0] oDataA,
  output logic [DATA_W-1:0] oDataB,
  output logic [1:0]        oTagA,
  output logic [1:0]        oTagB,
  output logic [1:0]        oCall,
  input  logic [1:0]        iDone,
  input  logic [1:0]        iTag,
  output logic [DATA_W-1:0] oData,
  input  logic [DATA_W-1:0] iData,
  output logic [1:0]        oGrant
);

  state_t     rState;
  logic [1:0] rGrant;
  logic [1:0] rCall;
  logic [1:0] rDoneA;
  logic [1:0] rDoneB;

  logic       wReqA;
  logic       wReqB;
  logic       wLastServed;
  logic [1:0] wSel;
  logic [1:0] wOwnerCall;
  logic       wOpDone;

  assign wReqA = |iCallA;
  assign wReqB = |iCallB;

`ifdef SDRAM_ARB_RR_EN
  logic rLastServed;

  always_ff @(posedge CLOCK) begin
    if (RESET)
      rLastServed <= LAST_B;
    else if (rState == IDLE && wSel != 2'b00)
      rLastServed <= wSel[1] ? LAST_B : LAST_A;
  end

  assign wLastServed = rLastServed;
`else
  // Pinning last-served to B makes every tie resolve to A.
  assign wLastServed = LAST_B;
`endif

  sdram_arbselmod uSel (
    .reqA       (wReqA),
    .reqB       (wReqB),
    .lastServed (wLastServed),
    .grant      (wSel)
  );

  assign wOwnerCall = wSel[1] ? iCallB : iCallA;
  // rCall is one-hot on the latched op throughout ISSUE, so it masks iDone.
  assign wOpDone    = (rCall & iDone) != 2'b00;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rState <= IDLE;
      rGrant <= 2'b00;
      rCall  <= 2'b00;
      rDoneA <= 2'b00;
      rDoneB <= 2'b00;
    end else begin
      rDoneA <= 2'b00;
      rDoneB <= 2'b00;
      case (rState)
        IDLE: begin
          if (wSel != 2'b00) begin
            rGrant <= wSel;
            rCall  <= opToCall(wOwnerCall[CALL_WR]);
            rState <= ISSUE;
          end
        end
        ISSUE: begin
          if (wOpDone) begin
            rCall  <= 2'b00;
            rDoneA <= rGrant[0] ? rCall : 2'b00;
            rDoneB <= rGrant[1] ? rCall : 2'b00;
            rState <= DRAIN;
          end
        end
        DRAIN: begin
          rGrant <= 2'b00;
          rState <= IDLE;
        end
        default: begin
          rGrant <= 2'b00;
          rCall  <= 2'b00;
          rState <= IDLE;
        end
      endcase
    end
  end

  assign oCall  = rCall;
  assign oGrant = rGrant;
  assign oDoneA = rDoneA;
  assign oDoneB = rDoneB;
  assign oDataA = iData;
  assign oDataB = iData;
  assign oTagA  = rGrant[0] ? iTag : 2'b00;
  assign oTagB  = rGrant[1] ? iTag : 2'b00;
  assign oData  = (rState == ISSUE) ? (rGrant[1] ? iDataB : iDataA) : '0;

endmodule

`default_nettype wire
